bcd_serial_adder: RTL and testbench

Digit-serial multi-digit BCD adder controller. It latches two packed N-digit BCD operands, checks that every digit is valid, and adds them one digit per clock, least-significant digit first. Each digit goes through a single-digit BCD add stage (binary add, then +6 correction when the result exceeds 9), with the decimal carry held in a register. Sits upstream of result formatting/display; feeds the digit adder and collects its per-digit results.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 150 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, digit type and controller state encoding for the digit-serial BCD adder.
package bcd_pkg;
   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_CORR = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic bcd_digit_ok(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD add: binary sum of two digits plus carry, then +6 correction above 9.
import bcd_pkg::*;

module bcd_digit_add (
   input  logic [3:0] a_d,
   input  logic [3:0] b_d,
   input  logic       cin,
   output logic [3:0] s_d,
   output logic       cout
);
   logic [4:0] w_t;
   logic [4:0] w_t_corr;

   always_comb begin
      w_t      = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, cin};
      w_t_corr = w_t + {1'b0, BCD_CORR};
      if (w_t > {1'b0, BCD_MAX}) begin
         s_d  = w_t_corr[3:0];
         cout = 1'b1;
      end else begin
         s_d  = w_t[3:0];
         cout = 1'b0;
      end
   end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder controller, LSD first, one digit per clock.
// Optional subtract mode (a-b via nines complement of b) when BCD_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; operands latched and validated on start
// ADD   | one digit of the latched operands added per clock
// DONE  | one-cycle completion pulse; result held afterwards
import bcd_pkg::*;

module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [DIGITS*DIGIT_W-1:0]   a,
   input  logic [DIGITS*DIGIT_W-1:0]   b,
`ifdef BCD_SUB_EN
   input  logic                        sub,
`endif
   output logic                        busy,
   output logic                        done,
   output logic [DIGITS*DIGIT_W-1:0]   sum,
   output logic                        cout,
   output logic                        err
);
   localparam int W     = DIGITS * DIGIT_W;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

   state_t             r_state;
   state_t             w_next;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_sum;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_cout;
   logic               r_err;

   logic               w_valid;
   logic               w_last;
   logic               w_cin0;
   logic [W-1:0]       w_b_eff;
   bcd_digit_t         w_a_d;
   bcd_digit_t         w_b_d;
   bcd_digit_t         w_s_d;
   logic               w_c;

   always_comb begin
      w_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (!bcd_digit_ok(a[i*DIGIT_W +: DIGIT_W]) || !bcd_digit_ok(b[i*DIGIT_W +: DIGIT_W]))
            w_valid = 1'b0;
      end
   end

`ifdef BCD_SUB_EN
   // Complement is applied after validity checking so invalid b digits still flag err.
   always_comb begin
      w_b_eff = b;
      if (sub) begin
         for (int i = 0; i < DIGITS; i++)
            w_b_eff[i*DIGIT_W +: DIGIT_W] = BCD_MAX - b[i*DIGIT_W +: DIGIT_W];
      end
   end
   assign w_cin0 = sub;
`else
   assign w_b_eff = b;
   assign w_cin0  = 1'b0;
`endif

   always_comb begin
      w_a_d = '0;
      w_b_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_a_d = r_a[i*DIGIT_W +: DIGIT_W];
            w_b_d = r_b[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   bcd_digit_add u_digit_add (
      .a_d  (w_a_d),
      .b_d  (w_b_d),
      .cin  (r_carry),
      .s_d  (w_s_d),
      .cout (w_c)
   );

   assign w_last = (r_idx == LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = w_valid ? ADD : DONE;
         ADD:     if (w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= w_b_eff;
                  r_sum   <= '0;
                  r_idx   <= '0;
                  r_carry <= w_cin0;
                  r_cout  <= 1'b0;
                  r_err   <= ~w_valid;
               end
            end
            ADD: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (r_idx == IDX_W'(i))
                     r_sum[i*DIGIT_W +: DIGIT_W] <= w_s_d;
               end
               r_carry <= w_c;
               r_idx   <= r_idx + 1'b1;
               if (w_last) r_cout <= w_c;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state == ADD);
   assign done = (r_state == DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign err  = r_err;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4); subtract vectors run when BCD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_bcd_serial_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        sub_i;
   logic        busy, done, cout, err;
   logic [15:0] sum;

   int n_cmp = 0;
   int n_err = 0;
   int lat, bcnt, dcnt;

   always #5 clk = ~clk;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef BCD_SUB_EN
      .sub   (sub_i),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts one operation and watches 12 cycles: first done cycle (1 = cycle after start edge),
   // busy cycle count and done pulse count. Inputs are scrambled after the accepting edge.
   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         output int o_lat, output int o_bcnt, output int o_dcnt);
      @(negedge clk);
      a = va; b = vb; sub_i = vs; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; sub_i = ~vs;
      o_lat = 0; o_bcnt = 0; o_dcnt = 0;
      for (int k = 1; k <= 12; k++) begin
         if (busy) o_bcnt++;
         if (done) begin
            o_dcnt++;
            if (o_lat == 0) o_lat = k;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_sum",  {16'b0, sum},  0);
      chk("rst_cout", {31'b0, cout}, 0);
      chk("rst_err",  {31'b0, err},  0);
      rst = 1'b0;

      run_op(16'h0042, 16'h0058, 1'b0, lat, bcnt, dcnt);
      chk("a42_lat",  lat,  5);
      chk("a42_busy", bcnt, 4);
      chk("a42_done", dcnt, 1);
      chk("a42_sum",  {16'b0, sum}, 32'h0100);
      chk("a42_cout", {31'b0, cout}, 0);
      chk("a42_err",  {31'b0, err},  0);

      run_op(16'h9999, 16'h0001, 1'b0, lat, bcnt, dcnt);
      chk("a9999p1_sum",  {16'b0, sum}, 32'h0000);
      chk("a9999p1_cout", {31'b0, cout}, 1);

      run_op(16'h9999, 16'h9999, 1'b0, lat, bcnt, dcnt);
      chk("max_sum",  {16'b0, sum}, 32'h9998);
      chk("max_cout", {31'b0, cout}, 1);

      run_op(16'h5678, 16'h4321, 1'b0, lat, bcnt, dcnt);
      chk("nocarry_sum",  {16'b0, sum}, 32'h9999);
      chk("nocarry_cout", {31'b0, cout}, 0);

      run_op(16'h0905, 16'h0195, 1'b0, lat, bcnt, dcnt);
      chk("chain_sum",  {16'b0, sum}, 32'h1100);
      chk("chain_cout", {31'b0, cout}, 0);

      run_op(16'h00A3, 16'h0001, 1'b0, lat, bcnt, dcnt);
      chk("errA_lat",  lat,  1);
      chk("errA_busy", bcnt, 0);
      chk("errA_done", dcnt, 1);
      chk("errA_err",  {31'b0, err},  1);
      chk("errA_sum",  {16'b0, sum},  0);
      chk("errA_cout", {31'b0, cout}, 0);

      run_op(16'h0001, 16'hF000, 1'b0, lat, bcnt, dcnt);
      chk("errB_err", {31'b0, err}, 1);

      run_op(16'h0011, 16'h0022, 1'b0, lat, bcnt, dcnt);
      chk("clr_err", {31'b0, err}, 0);
      chk("clr_sum", {16'b0, sum}, 32'h0033);

      // Second start during ADD must be ignored.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dcnt = 0;
      if (done) dcnt++;
      @(negedge clk);
      a = 16'h5000; b = 16'h4000; start = 1'b1;
      if (done) dcnt++;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done) dcnt++;
         @(negedge clk);
      end
      chk("ign_sum",  {16'b0, sum}, 32'h2345);
      chk("ign_done", dcnt, 1);

      // Reset during the third ADD cycle.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_done", {31'b0, done}, 0);
      chk("abort_sum",  {16'b0, sum},  0);
      chk("abort_cout", {31'b0, cout}, 0);
      chk("abort_err",  {31'b0, err},  0);
      run_op(16'h0042, 16'h0058, 1'b0, lat, bcnt, dcnt);
      chk("post_lat", lat, 5);
      chk("post_sum", {16'b0, sum}, 32'h0100);

`ifdef BCD_SUB_EN
      run_op(16'h0100, 16'h0001, 1'b1, lat, bcnt, dcnt);
      chk("sub1_sum",  {16'b0, sum}, 32'h0099);
      chk("sub1_cout", {31'b0, cout}, 1);
      chk("sub1_lat",  lat, 5);
      run_op(16'h0001, 16'h0002, 1'b1, lat, bcnt, dcnt);
      chk("sub2_sum",  {16'b0, sum}, 32'h9999);
      chk("sub2_cout", {31'b0, cout}, 0);
      run_op(16'h0042, 16'h0058, 1'b0, lat, bcnt, dcnt);
      chk("sub0_sum",  {16'b0, sum}, 32'h0100);
      chk("sub0_cout", {31'b0, cout}, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
